// File: rtl/fsm_seq_ctrl_pkg.sv
// Shared definitions for the FSM test-sequencing controller: state encoding and
// the layout of one stimulus vector {exp_y, x1, x2}.
package fsm_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFrst  = 3'd1,
      StDrive = 3'd2,
      StCheck = 3'd3,
      StFin   = 3'd4
   } seq_state_e;

   localparam int unsigned X2Bit   = 0;
   localparam int unsigned X1Bit   = 1;
   localparam int unsigned ExpYBit = 2;
   localparam int unsigned VecW    = 3;

endpackage

// File: rtl/fsm_seq_ctrl_mem.sv
// Vector table: DEPTH x 3 register file, synchronous write, combinational read.
// Contents are deliberately not reset so a table survives a controller reset.
module fsm_seq_ctrl_mem
   import fsm_seq_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic            i_clk,
   input  logic            i_wr_en,
   input  logic [AW-1:0]   i_wr_addr,
   input  logic [VecW-1:0] i_wr_data,
   input  logic [AW-1:0]   i_rd_addr,
   output logic [VecW-1:0] o_rd_data
);

   logic [VecW-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Test sequencer for a two-input Moore FSM: resets it, plays the vector table on
// x1/x2, compares y after each step and reports mismatch count / first failure.
module fsm_seq_ctrl
   import fsm_seq_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned ECW   = 8
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_wr_en,
   input  logic [AW-1:0]   i_wr_addr,
   input  logic [VecW-1:0] i_wr_data,
   input  logic [AW:0]     i_len,
   input  logic            i_start,
   input  logic            i_abort,
   output logic            o_fsm_rstn,
   output logic            o_x1,
   output logic            o_x2,
   input  logic            i_y,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
   output logic [ECW-1:0]  o_err_cnt,
   output logic [AW-1:0]   o_first_err
);

   localparam logic [AW:0]    DepthW = (AW+1)'(DEPTH);
   localparam logic [ECW-1:0] ErrMax = '1;

   seq_state_e      r_state, w_state_d;
   logic [AW:0]     r_n, w_n_d;
   logic [AW-1:0]   r_idx, w_idx_d;
   logic            r_fsm_rstn, w_fsm_rstn_d;
   logic            r_x1, w_x1_d;
   logic            r_x2, w_x2_d;
   logic            r_exp_y, w_exp_y_d;
   logic            r_busy, w_busy_d;
   logic            r_done, w_done_d;
   logic            r_pass, w_pass_d;
   logic [ECW-1:0]  r_err_cnt, w_err_cnt_d;
   logic [AW-1:0]   r_first_err, w_first_err_d;

   logic [AW:0]     w_len_clamp;
   logic [AW-1:0]   w_rd_addr;
   logic [VecW-1:0] w_rd_data;
   logic            w_last;
   logic            w_mismatch;
   logic [ECW-1:0]  w_err_inc;
   logic            w_abort;

   fsm_seq_ctrl_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk     (i_clk),
      .i_wr_en   (i_wr_en & ~r_busy),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   assign w_len_clamp = (i_len > DepthW) ? DepthW : i_len;
   // In CHECK the read port looks ahead to the vector loaded for the next DRIVE.
   assign w_rd_addr   = (r_state == StCheck) ? r_idx + 1'b1 : r_idx;
   assign w_last      = ({1'b0, r_idx} == r_n - 1'b1);
   assign w_mismatch  = (i_y != r_exp_y);
   assign w_err_inc   = (w_mismatch && (r_err_cnt != ErrMax)) ? r_err_cnt + 1'b1 : r_err_cnt;
   assign w_abort     = i_abort && (r_state != StIdle);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_d = (w_len_clamp == '0) ? StFin : StFrst;
         StFrst:  w_state_d = StDrive;
         StDrive: w_state_d = StCheck;
         StCheck: w_state_d = w_last ? StFin : StDrive;
         StFin:   w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
      if (w_abort) w_state_d = StIdle;
   end

   always_comb begin
      w_n_d         = r_n;
      w_idx_d       = r_idx;
      w_fsm_rstn_d  = r_fsm_rstn;
      w_x1_d        = r_x1;
      w_x2_d        = r_x2;
      w_exp_y_d     = r_exp_y;
      w_busy_d      = r_busy;
      w_done_d      = 1'b0;
      w_pass_d      = r_pass;
      w_err_cnt_d   = r_err_cnt;
      w_first_err_d = r_first_err;
      unique case (r_state)
         StIdle: begin
            w_fsm_rstn_d = 1'b1;
            w_x1_d       = 1'b0;
            w_x2_d       = 1'b0;
            if (i_start) begin
               w_n_d         = w_len_clamp;
               w_idx_d       = '0;
               w_err_cnt_d   = '0;
               w_first_err_d = '0;
               w_pass_d      = 1'b0;
               if (w_len_clamp == '0) begin
                  w_pass_d = 1'b1;
                  w_done_d = 1'b1;
               end else begin
                  w_busy_d     = 1'b1;
                  w_fsm_rstn_d = 1'b0;
               end
            end
         end
         StFrst: begin
            w_fsm_rstn_d = 1'b1;
            w_x1_d       = w_rd_data[X1Bit];
            w_x2_d       = w_rd_data[X2Bit];
            w_exp_y_d    = w_rd_data[ExpYBit];
         end
         StDrive: ;
         StCheck: begin
            w_err_cnt_d = w_err_inc;
            if (w_mismatch && (r_err_cnt == '0)) w_first_err_d = r_idx;
            if (w_last) begin
               w_busy_d = 1'b0;
               w_done_d = 1'b1;
               w_pass_d = (w_err_inc == '0);
               w_x1_d   = 1'b0;
               w_x2_d   = 1'b0;
            end else begin
               w_idx_d   = r_idx + 1'b1;
               w_x1_d    = w_rd_data[X1Bit];
               w_x2_d    = w_rd_data[X2Bit];
               w_exp_y_d = w_rd_data[ExpYBit];
            end
         end
         StFin: begin
            w_x1_d = 1'b0;
            w_x2_d = 1'b0;
         end
         default: ;
      endcase
      // Abort drops the in-flight compare and keeps the partial error record.
      if (w_abort) begin
         w_busy_d      = 1'b0;
         w_done_d      = 1'b0;
         w_pass_d      = 1'b0;
         w_x1_d        = 1'b0;
         w_x2_d        = 1'b0;
         w_fsm_rstn_d  = 1'b1;
         w_err_cnt_d   = r_err_cnt;
         w_first_err_d = r_first_err;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_n         <= '0;
         r_idx       <= '0;
         r_fsm_rstn  <= 1'b0;
         r_x1        <= 1'b0;
         r_x2        <= 1'b0;
         r_exp_y     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
      end else begin
         r_n         <= w_n_d;
         r_idx       <= w_idx_d;
         r_fsm_rstn  <= w_fsm_rstn_d;
         r_x1        <= w_x1_d;
         r_x2        <= w_x2_d;
         r_exp_y     <= w_exp_y_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_pass      <= w_pass_d;
         r_err_cnt   <= w_err_cnt_d;
         r_first_err <= w_first_err_d;
      end
   end

   assign o_fsm_rstn  = r_fsm_rstn;
   assign o_x1        = r_x1;
   assign o_x2        = r_x2;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_err_cnt   = r_err_cnt;
   assign o_first_err = r_first_err;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: a behavioural Moore FSM answers on y, run results are
// scoreboarded on done, and table-driven runs are followed by abort/reset cases.
module tb_fsm_seq_ctrl;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned ECW   = 8;

   logic          clk;
   logic          rstn;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [2:0]    wr_data;
   logic [AW:0]   len;
   logic          start;
   logic          abort;
   logic          fsm_rstn;
   logic          x1;
   logic          x2;
   logic          y;
   logic          busy;
   logic          done;
   logic          pass;
   logic [ECW-1:0] err_cnt;
   logic [AW-1:0] first_err;

   int n_chk  = 0;
   int n_fail = 0;

   fsm_seq_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .ECW   (ECW)
   ) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_wr_en     (wr_en),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_len       (len),
      .i_start     (start),
      .i_abort     (abort),
      .o_fsm_rstn  (fsm_rstn),
      .o_x1        (x1),
      .o_x2        (x2),
      .i_y         (y),
      .o_busy      (busy),
      .o_done      (done),
      .o_pass      (pass),
      .o_err_cnt   (err_cnt),
      .o_first_err (first_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Moore FSM under test: 00 hold, 01 increment, 10 clear, 11 invert; y when state is 3.
   function automatic logic [1:0] fsm_nxt(input logic [1:0] s, input logic [1:0] x);
      case (x)
         2'b00:   return s;
         2'b01:   return s + 2'd1;
         2'b10:   return 2'd0;
         default: return ~s;
      endcase
   endfunction

   logic [1:0] r_fs;
   always_ff @(posedge clk or negedge fsm_rstn) begin
      if (!fsm_rstn) r_fs <= 2'd0;
      else           r_fs <= fsm_nxt(r_fs, {x1, x2});
   end
   assign y = (r_fs == 2'd3);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic           pass;
      logic [ECW-1:0] err;
      logic [AW-1:0]  first;
   } res_t;

   res_t sb_q[$];

   always @(negedge clk) begin
      if (rstn && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            res_t r;
            r = sb_q.pop_front();
            check("sb_pass", 32'(pass), 32'(r.pass));
            check("sb_err_cnt", 32'(err_cnt), 32'(r.err));
            check("sb_first_err", 32'(first_err), 32'(r.first));
         end
      end
   end

   logic [1:0] xs   [DEPTH];
   logic       gold [DEPTH];

   typedef struct {
      logic [AW:0]     len;
      logic [DEPTH-1:0] inv;
      logic            pass;
      logic [ECW-1:0]  err;
      logic [AW-1:0]   first;
      int              busy;
   } vec_t;

   vec_t tbl [6];

   task automatic load_table(input logic [DEPTH-1:0] inv);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = AW'(i);
         wr_data = {gold[i] ^ inv[i], xs[i]};
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic run_and_check(input logic [AW:0] l, input logic p, input logic [ECW-1:0] e,
                                input logic [AW-1:0] f, input int busy_exp);
      int n_busy = 0;
      int n_rst  = 0;
      int n_done = 0;
      int after  = -1;
      int n;
      logic ok;
      logic [1:0] xq[$];
      n = (int'(l) > DEPTH) ? DEPTH : int'(l);
      sb_q.push_back(res_t'{pass: p, err: e, first: f});
      @(negedge clk);
      len   = l;
      start = 1'b1;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) n_busy++;
         if (!fsm_rstn) n_rst++;
         if (busy && fsm_rstn) xq.push_back({x1, x2});
         if (done) n_done++;
         if (n_done > 0 && after < 0) after = k;
         if (after >= 0 && k >= after + 3) break;
      end
      check("done_pulses", 32'(n_done), 32'd1);
      check("busy_cycles", 32'(n_busy), 32'(busy_exp));
      check("fsm_rstn_low", 32'(n_rst), (n == 0) ? 32'd0 : 32'd1);
      ok = (xq.size() == 2 * n);
      if (ok) begin
         for (int i = 0; i < n; i++) begin
            if (xq[2*i] != xs[i] || xq[2*i+1] != xs[i]) ok = 1'b0;
         end
      end
      check("x_sequence", 32'(ok), 32'd1);
      check("sb_drain", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      logic [1:0] s;
      xs = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11,
             2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b01};
      // Each vector clocks the FSM twice (end of DRIVE, end of CHECK); y is checked after the first.
      s = 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
         s       = fsm_nxt(s, xs[i]);
         gold[i] = (s == 2'd3);
         s       = fsm_nxt(s, xs[i]);
      end

      tbl[0] = '{len: 5'd8,  inv: 16'h0000, pass: 1'b1, err: 8'd0, first: 4'd0, busy: 17};
      tbl[1] = '{len: 5'd8,  inv: 16'h0024, pass: 1'b0, err: 8'd2, first: 4'd2, busy: 17};
      tbl[2] = '{len: 5'd0,  inv: 16'h0000, pass: 1'b1, err: 8'd0, first: 4'd0, busy: 0};
      tbl[3] = '{len: 5'd31, inv: 16'h0000, pass: 1'b1, err: 8'd0, first: 4'd0, busy: 33};
      tbl[4] = '{len: 5'd16, inv: 16'h8200, pass: 1'b0, err: 8'd2, first: 4'd9, busy: 33};
      tbl[5] = '{len: 5'd3,  inv: 16'h0080, pass: 1'b1, err: 8'd0, first: 4'd0, busy: 7};

      rstn    = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      len     = '0;
      start   = 1'b0;
      abort   = 1'b0;
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_first_err", 32'(first_err), 32'd0);
      check("rst_fsm_rstn", 32'(fsm_rstn), 32'd0);
      check("rst_x", 32'({x1, x2}), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("idle_fsm_rstn", 32'(fsm_rstn), 32'd1);

      for (int t = 0; t < 6; t++) begin
         load_table(tbl[t].inv);
         run_and_check(tbl[t].len, tbl[t].pass, tbl[t].err, tbl[t].first, tbl[t].busy);
      end

      // Abort in CHECK of vector 3, with start and a table write attempted mid-run.
      load_table(16'h0002);
      @(negedge clk);
      len   = 5'd8;
      start = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         start = 1'b0;
         wr_en = 1'b0;
         if (k == 3) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = {~gold[0], xs[0]};
         end
         if (k == 4) begin
            check("busy_start_ignored_busy", 32'(busy), 32'd1);
            check("busy_start_ignored_rstn", 32'(fsm_rstn), 32'd1);
         end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_pass", 32'(pass), 32'd0);
      check("abort_x", 32'({x1, x2}), 32'd0);
      check("abort_err_cnt", 32'(err_cnt), 32'd1);
      check("abort_first_err", 32'(first_err), 32'd1);
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      run_and_check(5'd8, 1'b0, 8'd1, 4'd1, 17);

      // Asynchronous reset during DRIVE of vector 2; the table must survive.
      load_table(16'h0000);
      @(negedge clk);
      len   = 5'd8;
      start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 rstn = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_fsm_rstn", 32'(fsm_rstn), 32'd0);
      check("mid_rst_x", 32'({x1, x2}), 32'd0);
      check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      #4 rstn = 1'b1;
      run_and_check(5'd8, 1'b1, 8'd0, 4'd0, 17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
